add_seq_ctrl: RTL and testbench
===============================

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

Interface
REQ-001 Parameter NBYTES, default 4, number of 8-bit slices per operand (2..8); operand width W = 8*NBYTES.
REQ-002 The block SHALL use one clock and an asynchronous active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester 0/1 has an add pending.
REQ-006 req0_ready / req1_ready  output  1  request accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  W  operands.
REQ-008 req0_cin / req1_cin  input  1  carry in.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_sum  output  W  result; rsp_cout  output  1  carry out; rsp_id  output  1  granted requester.

Function
REQ-012 FSM states IDLE, RUN, DONE; IDLE->RUN on accept; RUN->DONE after slice NBYTES-1; DONE->IDLE when rsp_valid&&rsp_ready.
REQ-013 reqN_ready SHALL be combinational, high only in IDLE for the granted requester with reqN_valid high; at most one ready high per cycle.
REQ-014 Arbitration round-robin: both valid -> grant the requester not granted last; one valid -> grant it; last-grant pointer updates only on accept.
REQ-015 On accept, operands, cin and id SHALL be captured in registers; later changes on req inputs have no effect.
REQ-016 RUN: one 8-bit slice per cycle, LSB first, slice k = a[8k+7:8k]+b[8k+7:8k]+carry; carry for slice 0 = captured cin, for slice k>0 = cout of slice k-1.
REQ-017 rsp_valid SHALL rise exactly NBYTES cycles after the accepting edge and hold, with rsp_sum/rsp_cout/rsp_id stable, until rsp_ready sampled high.
REQ-018 rsp_ready while rsp_valid low SHALL be ignored; no new accept in the same cycle the response is taken (next accept earliest the following cycle).
REQ-019 Arithmetic: {rsp_cout,rsp_sum} = a+b+cin modulo 2^(W+1); all-ones + 0 + 1 -> sum 0, cout 1.

Reset
REQ-020 rst_n low SHALL force IDLE, slice index 0, carry 0, rsp_valid 0, rsp_sum 0, rsp_cout 0, rsp_id 0, last-grant pointer = 1 (req0 wins first tie).
REQ-021 Reset mid-RUN or in DONE SHALL abort the operation with no response; both ready outputs low while rst_n low.

Configuration
REQ-022 Macro ADD_SEQ_SAT_EN defined: if final carry is 1, rsp_sum SHALL be all-ones, rsp_cout 1.
REQ-023 ADD_SEQ_SAT_EN undefined: wrap-around result per REQ-019; no other behaviour differs.

Structure
REQ-024 Package add_seq_pkg SHALL hold the FSM state enum and slice width constant SLICE_W = 8.
REQ-025 One sub-module, adder8 (8-bit a, b, cin -> 8-bit sum, cout, combinational), instantiated once and time-shared across slices.

Verification
REQ-026 req0 only, a=0x0000_00FF, b=0x0000_0001, cin=0 -> rsp_sum 0x0000_0100, cout 0, id 0, rsp_valid 4 cycles after accept.
REQ-027 Both valid from reset, req0 a=1,b=2; req1 a=0x10,b=0x20; rsp_ready held 1 -> first response id 0 sum 3, second id 1 sum 0x30.
REQ-028 a=0xFFFF_FFFF, b=0, cin=1 -> sum 0x0000_0000 cout 1; with ADD_SEQ_SAT_EN -> sum 0xFFFF_FFFF cout 1.
REQ-029 rsp_ready held 0 for 10 cycles in DONE -> rsp_valid and outputs stable, both ready low; release -> IDLE next cycle.
REQ-030 rst_n pulsed low at slice 2 of an add -> rsp_valid never asserts for it; next request after reset completes correctly (0x1234_5678+0x1111_1111 -> 0x2345_6789).
REQ-031 Operands changed on req0_a during RUN -> result reflects captured values only.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the sequential slice adder.
package add_seq_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_ctrl_adder8.sv
// Combinational 8-bit slice adder, time-shared by add_seq_ctrl.
module adder8
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  always_comb begin
    {cout, sum} = a + b + {{(SLICE_W-1){1'b0}}, cin};
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Two-requester round-robin adder computing one 8-bit slice per cycle, LSB first.
// Optional saturation on final carry when ADD_SEQ_SAT_EN is defined.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int unsigned NBYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [SLICE_W*NBYTES-1:0]   req0_a,
  input  logic [SLICE_W*NBYTES-1:0]   req0_b,
  input  logic                        req0_cin,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [SLICE_W*NBYTES-1:0]   req1_a,
  input  logic [SLICE_W*NBYTES-1:0]   req1_b,
  input  logic                        req1_cin,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [SLICE_W*NBYTES-1:0]   rsp_sum,
  output logic                        rsp_cout,
  output logic                        rsp_id
);

  localparam int unsigned W  = SLICE_W * NBYTES;
  localparam int unsigned IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t             state_q, state_d;
  logic               last_q;
  logic [IW-1:0]      idx_q;
  logic               carry_q;
  logic [W-1:0]       a_q, b_q, sum_q;
  logic               cout_q, id_q;

  logic               grant0, grant1, accept, take, last_slice;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [W-1:0]       sum_shift, sum_fin;

  adder8 u_adder (
    .a    (a_q[SLICE_W-1:0]),
    .b    (b_q[SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // last_q names the previous winner; on a tie the other side is granted
  always_comb begin
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    accept     = (state_q == IDLE) && (grant0 || grant1);
    take       = (state_q == DONE) && rsp_ready;
    last_slice = (state_q == RUN) && (idx_q == LAST);
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (take)       state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Result assembles in a shift register: each new slice enters at the top,
  // so after NBYTES slices slice 0 has reached bit 0.
  always_comb begin
    sum_shift = {slice_sum, sum_q[W-1:SLICE_W]};
    sum_fin   = sum_shift;
`ifdef ADD_SEQ_SAT_EN
    if (slice_cout) sum_fin = '1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          a_q     <= grant1 ? req1_a : req0_a;
          b_q     <= grant1 ? req1_b : req0_b;
          carry_q <= grant1 ? req1_cin : req0_cin;
          id_q    <= grant1;
          last_q  <= grant1;
          idx_q   <= '0;
        end
        RUN: begin
          a_q     <= a_q >> SLICE_W;
          b_q     <= b_q >> SLICE_W;
          carry_q <= slice_cout;
          if (last_slice) begin
            idx_q  <= '0;
            sum_q  <= sum_fin;
            cout_q <= slice_cout;
          end else begin
            idx_q  <= idx_q + 1'b1;
            sum_q  <= sum_shift;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_valid = (state_q == DONE);
    rsp_sum   = sum_q;
    rsp_cout  = cout_q;
    rsp_id    = id_q;
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl (NBYTES = 4).
module tb_add_seq_ctrl;

  localparam int unsigned W = 32;

  logic         clk, rst_n;
  logic         req0_valid, req0_ready, req0_cin;
  logic         req1_valid, req1_ready, req1_cin;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [W-1:0] rsp_sum;

  int total = 0;
  int bad   = 0;

  add_seq_ctrl #(.NBYTES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_id     (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one request at a negedge, hold it across one posedge, then drop it.
  task automatic issue(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output logic rdy);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
    end
    #1 rdy = id ? req1_ready : req0_ready;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until rsp_valid is seen (capped at 20).
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!rsp_valid && lat < 20);
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({rsp_valid, rsp_cout, rsp_id, rsp_sum} !== {3'b000, 32'h0}) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b cout=%b id=%b sum=%h, required 0 0 0 00000000",
               rsp_valid, rsp_cout, rsp_id, rsp_sum);
    end
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL reset_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic rdy;
    int   lat;
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0, rdy);
    total++;
    if (rdy !== 1'b1) begin bad++; $display("FAIL single_ready: got %b, required 1", rdy); end
    wait_rsp(lat);
    total++;
    if (lat != 4) begin bad++; $display("FAIL single_latency: got %0d, required 4", lat); end
    total++;
    if ({rsp_cout, rsp_id, rsp_sum} !== {2'b00, 32'h0000_0100}) begin
      bad++;
      $display("FAIL single_result: cout=%b id=%b sum=%h, required 0 0 00000100",
               rsp_cout, rsp_id, rsp_sum);
    end
    take_rsp();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_release: valid=%b, required 0", rsp_valid); end
  endtask

  task automatic test_tie();
    int lat;
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h1;  req0_b = 32'h2;  req0_cin = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h10; req1_b = 32'h20; req1_cin = 1'b0;
    rsp_ready  = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++;
      $display("FAIL tie_first_grant: ready0=%b ready1=%b, required 1 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL tie_run_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
    end
    wait_rsp(lat);
    total++;
    if ({lat == 4, rsp_id, rsp_sum} !== {2'b10, 32'h3}) begin
      bad++;
      $display("FAIL tie_first_rsp: lat=%0d id=%b sum=%h, required 4 0 00000003", lat, rsp_id, rsp_sum);
    end
    total++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      bad++;
      $display("FAIL tie_done_ready: ready0=%b ready1=%b, required 0 0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b001) begin
      bad++;
      $display("FAIL tie_second_grant: valid=%b ready0=%b ready1=%b, required 0 0 1",
               rsp_valid, req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(lat);
    total++;
    if ({lat == 4, rsp_id, rsp_sum} !== {2'b11, 32'h30}) begin
      bad++;
      $display("FAIL tie_second_rsp: lat=%0d id=%b sum=%h, required 4 1 00000030", lat, rsp_id, rsp_sum);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL tie_release: valid=%b, required 0", rsp_valid); end
  endtask

  task automatic test_carry();
    logic         vid  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] va   [4] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h12FF_FF80, 32'h00FF_00FF};
    logic [W-1:0] vb   [4] = '{32'h0000_0000, 32'h8000_0001, 32'h0000_0080, 32'h0001_0001};
    logic         vcin [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`ifdef ADD_SEQ_SAT_EN
    logic [W-1:0] vsum [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1300_0001, 32'h0100_0100};
`else
    logic [W-1:0] vsum [4] = '{32'h0000_0000, 32'h0000_0001, 32'h1300_0001, 32'h0100_0100};
`endif
    logic         vco  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic rdy;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      issue(vid[i], va[i], vb[i], vcin[i], rdy);
      wait_rsp(lat);
      total++;
      if ({rdy, lat == 4, rsp_id, rsp_cout, rsp_sum} !== {2'b11, vid[i], vco[i], vsum[i]}) begin
        bad++;
        $display("FAIL carry_vec%0d: rdy=%b lat=%0d id=%b cout=%b sum=%h, required 1 4 %b %b %h",
                 i, rdy, lat, rsp_id, rsp_cout, rsp_sum, vid[i], vco[i], vsum[i]);
      end
      take_rsp();
    end
  endtask

  task automatic test_hold();
    logic rdy;
    int   lat;
    issue(1'b0, 32'h0102_0304, 32'h1010_1010, 1'b1, rdy);
    wait_rsp(lat);
    total++;
    if ({rdy, lat == 4} !== 2'b11) begin
      bad++;
      $display("FAIL hold_start: rdy=%b lat=%0d, required 1 4", rdy, lat);
    end
    req1_valid = 1'b1; req1_a = 32'h5; req1_b = 32'h6; req1_cin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready, rsp_sum} !== {5'b10000, 32'h1112_1315}) begin
        bad++;
        $display("FAIL hold_cycle%0d: valid=%b cout=%b id=%b ready0=%b ready1=%b sum=%h, required 1 0 0 0 0 11121315",
                 i, rsp_valid, rsp_cout, rsp_id, req0_ready, req1_ready, rsp_sum);
      end
    end
    take_rsp();
    total++;
    if ({rsp_valid, req1_ready} !== 2'b01) begin
      bad++;
      $display("FAIL hold_release: valid=%b ready1=%b, required 0 1", rsp_valid, req1_ready);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic rdy;
    int   lat;
    bit   seen;
    issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, rdy);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      bad++;
      $display("FAIL abort_in_reset: valid=%b ready0=%b ready1=%b, required 0 0 0",
               rsp_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 if (rsp_valid) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL abort_no_rsp: valid seen=%b, required 0", seen); end
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, rdy);
    wait_rsp(lat);
    total++;
    if ({rdy, lat == 4, rsp_id, rsp_cout, rsp_sum} !== {4'b1100, 32'h2345_6789}) begin
      bad++;
      $display("FAIL abort_next: rdy=%b lat=%0d id=%b cout=%b sum=%h, required 1 4 0 0 23456789",
               rdy, lat, rsp_id, rsp_cout, rsp_sum);
    end
    take_rsp();
  endtask

  task automatic test_capture();
    logic rdy;
    int   lat;
    issue(1'b0, 32'h1111_1111, 32'h2222_2222, 1'b0, rdy);
    req0_a = 32'hFFFF_FFFF; req0_b = 32'hFFFF_FFFF; req0_cin = 1'b1;
    @(posedge clk);
    #1 req0_a = 32'h0F0F_0F0F;
    wait_rsp(lat);
    total++;
    if ({rdy, lat == 3, rsp_cout, rsp_sum} !== {3'b110, 32'h3333_3333}) begin
      bad++;
      $display("FAIL capture_result: rdy=%b lat=%0d cout=%b sum=%h, required 1 3 0 33333333",
               rdy, lat, rsp_cout, rsp_sum);
    end
    take_rsp();
    total++;
    if (rsp_valid !== 1'b0) begin bad++; $display("FAIL capture_release: valid=%b, required 0", rsp_valid); end
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_carry();
    test_hold();
    test_reset_abort();
    test_capture();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
